// File: rtl/uart_trans_cfg.sv
// uart_trans_cfg -- run-time configurable UART transmitter.
//
// Frame: start bit (0), DATA_BITS data bits LSB-first, optional parity bit,
// then one or two stop bits (1). Each bit lasts OVERSAMPLE sTick strobes.
//
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous, active-high reset
//   sTick       one-cycle baud oversample strobe
//   din         word to transmit, latched on acceptance
//   txStart     request to send din
//   parityMode  00 none, 01 even, 10 odd, 11 none; latched on acceptance
//   stopBits2   0 = one stop bit, 1 = two stop bits; latched on acceptance
//   txReady     high in IDLE: a txStart this cycle is accepted
//   txBusy      inverse of txReady
//   txDoneTick  one-cycle pulse on the final stop-bit sTick
//   tx          registered serial line, idle high
//   dbg_state   current FSM state (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4)
//
// Handshake: a transfer happens on a rising clk edge where txStart and
// txReady are both high. txStart while txReady is low is ignored (no
// queuing). din/parityMode/stopBits2 only need to be valid on that edge.
module uart_trans_cfg #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sTick,
  input  logic [DATA_BITS-1:0] din,
  input  logic                 txStart,
  input  logic [1:0]           parityMode,
  input  logic                 stopBits2,
  output logic                 txReady,
  output logic                 txBusy,
  output logic                 txDoneTick,
  output logic                 tx,
  output logic [2:0]           dbg_state
);

  localparam int BW = $clog2(DATA_BITS);
  localparam int TW = $clog2(2 * OVERSAMPLE);

  localparam logic [TW-1:0] LAST_TICK  = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] LAST_STOP2 = TW'(2 * OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT   = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t               state, state_n;
  logic [TW-1:0]        tick_cnt, tick_cnt_n;
  logic [BW-1:0]        bit_cnt, bit_cnt_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 par_en, par_en_n;
  logic                 par_bit, par_bit_n;
  logic                 stop2, stop2_n;
  logic                 tx_q, tx_n;
  logic                 done;

  // A normal bit ends on the sTick where the counter sits at OVERSAMPLE-1.
  // The stop phase simply runs the same counter further when two stop bits
  // were latched, so it needs no separate bit counter.
  logic bit_end;
  logic stop_end;
  assign bit_end  = sTick && (tick_cnt == LAST_TICK);
  assign stop_end = sTick && (tick_cnt == (stop2 ? LAST_STOP2 : LAST_TICK));

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_en   <= 1'b0;
      par_bit  <= 1'b0;
      stop2    <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      state    <= state_n;
      tick_cnt <= tick_cnt_n;
      bit_cnt  <= bit_cnt_n;
      shreg    <= shreg_n;
      par_en   <= par_en_n;
      par_bit  <= par_bit_n;
      stop2    <= stop2_n;
      tx_q     <= tx_n;
    end
  end

  always_comb begin
    state_n    = state;
    tick_cnt_n = tick_cnt;
    bit_cnt_n  = bit_cnt;
    shreg_n    = shreg;
    par_en_n   = par_en;
    par_bit_n  = par_bit;
    stop2_n    = stop2;
    done       = 1'b0;

    case (state)
      S_IDLE: begin
        if (txStart) begin
          state_n    = S_START;
          tick_cnt_n = '0;
          bit_cnt_n  = '0;
          shreg_n    = din;
          // Modes 01/10 enable parity; 11 behaves like 00.
          par_en_n   = parityMode[0] ^ parityMode[1];
          // Even parity sends the XOR of the data; odd (10) sends its inverse.
          par_bit_n  = (^din) ^ parityMode[1];
          stop2_n    = stopBits2;
        end
      end

      S_START: begin
        if (sTick) begin
          if (bit_end) begin
            state_n    = S_DATA;
            tick_cnt_n = '0;
          end else begin
            tick_cnt_n = tick_cnt + TW'(1);
          end
        end
      end

      S_DATA: begin
        if (sTick) begin
          if (bit_end) begin
            tick_cnt_n = '0;
            shreg_n    = shreg >> 1;
            if (bit_cnt == LAST_BIT) begin
              bit_cnt_n = '0;
              state_n   = par_en ? S_PARITY : S_STOP;
            end else begin
              bit_cnt_n = bit_cnt + BW'(1);
            end
          end else begin
            tick_cnt_n = tick_cnt + TW'(1);
          end
        end
      end

      S_PARITY: begin
        if (sTick) begin
          if (bit_end) begin
            state_n    = S_STOP;
            tick_cnt_n = '0;
          end else begin
            tick_cnt_n = tick_cnt + TW'(1);
          end
        end
      end

      S_STOP: begin
        if (sTick) begin
          if (stop_end) begin
            state_n    = S_IDLE;
            tick_cnt_n = '0;
            done       = 1'b1;
          end else begin
            tick_cnt_n = tick_cnt + TW'(1);
          end
        end
      end

      default: begin
        state_n    = S_IDLE;
        tick_cnt_n = '0;
        bit_cnt_n  = '0;
      end
    endcase

    // tx is registered from the next-state view so the line changes on the
    // same edge as the state: start bit appears one clk after acceptance.
    case (state_n)
      S_START:  tx_n = 1'b0;
      S_DATA:   tx_n = shreg_n[0];
      S_PARITY: tx_n = par_bit_n;
      default:  tx_n = 1'b1;
    endcase
  end

  assign tx         = tx_q;
  assign txReady    = (state == S_IDLE);
  assign txBusy     = (state != S_IDLE);
  // Gated by reset so a reset landing on the final stop tick abandons the
  // frame without a done pulse.
  assign txDoneTick = done && !reset;
  assign dbg_state  = state;

endmodule

// File: tb/tb_uart_trans_cfg.sv
// tb_uart_trans_cfg -- directed, table-driven bench for uart_trans_cfg.
// Two instances: DATA_BITS=8 and DATA_BITS=5, both OVERSAMPLE=16. A select
// bit routes txStart to one of them and muxes its outputs for checking.
module tb_uart_trans_cfg;

  localparam int OVS = 16;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       stick;
  logic [7:0] din;
  logic       start;
  logic [1:0] pmode;
  logic       s2;
  logic       use5;

  logic ready8, busy8, done8, tx8;
  logic ready5, busy5, done5, tx5;
  logic [2:0] dbg8, dbg5;
  logic start8, start5;
  logic [4:0] din5;

  assign start8 = start & ~use5;
  assign start5 = start & use5;
  assign din5   = din[4:0];

  uart_trans_cfg #(.DATA_BITS(8), .OVERSAMPLE(OVS)) dut8 (
    .clk(clk), .reset(reset), .sTick(stick), .din(din), .txStart(start8),
    .parityMode(pmode), .stopBits2(s2), .txReady(ready8), .txBusy(busy8),
    .txDoneTick(done8), .tx(tx8), .dbg_state(dbg8)
  );

  uart_trans_cfg #(.DATA_BITS(5), .OVERSAMPLE(OVS)) dut5 (
    .clk(clk), .reset(reset), .sTick(stick), .din(din5), .txStart(start5),
    .parityMode(pmode), .stopBits2(s2), .txReady(ready5), .txBusy(busy5),
    .txDoneTick(done5), .tx(tx5), .dbg_state(dbg5)
  );

  logic ready_m, busy_m, done_m, tx_m;
  assign ready_m = use5 ? ready5 : ready8;
  assign busy_m  = use5 ? busy5  : busy8;
  assign done_m  = use5 ? done5  : done8;
  assign tx_m    = use5 ? tx5    : tx8;

  // scoreboard
  int n_cmp = 0;
  int n_bad = 0;
  logic [0:0] exp_q[$];

  typedef struct {
    logic [7:0] din;
    logic [1:0] pm;
    logic       s2;
    int         sdiv;
    logic       use5;
    logic       exp_par;
    int         exp_len;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Drives one frame from an idle point (called at a negedge) and checks the
  // tx waveform, busy/ready, and the done pulse against the expected bits.
  task automatic run_frame(input vec_t v, input bit hold, input bit disturb, input string nm);
    int ticks, cyc, tx_err, busy_err, done_err, done_cnt, done_at, nbits;
    logic exp_done;
    nbits = v.use5 ? 5 : 8;
    exp_q.delete();
    exp_q.push_back(1'b0);
    for (int i = 0; i < nbits; i++) exp_q.push_back(v.din[i]);
    if (v.pm == 2'b01 || v.pm == 2'b10) exp_q.push_back(v.exp_par);
    exp_q.push_back(1'b1);
    if (v.s2) exp_q.push_back(1'b1);

    use5 = v.use5; din = v.din; pmode = v.pm; s2 = v.s2; start = 1'b1; stick = 1'b0;
    #1;
    check({nm, "_ready_at_accept"}, 32'(ready_m), 32'd1);
    @(posedge clk);

    ticks = 0; cyc = 0; tx_err = 0; busy_err = 0; done_err = 0; done_cnt = 0; done_at = -1;
    while (ticks < v.exp_len && cyc < 4000) begin
      @(negedge clk);
      start = hold;
      if (disturb) begin
        din   = 8'($urandom);
        pmode = 2'($urandom_range(0, 3));
        s2    = 1'($urandom_range(0, 1));
        start = 1'($urandom_range(0, 1));
      end
      if (tx_m !== exp_q[ticks / OVS][0]) tx_err++;
      if (busy_m !== 1'b1 || ready_m !== 1'b0) busy_err++;
      stick = ((cyc % v.sdiv) == (v.sdiv - 1));
      #1;
      exp_done = stick && (ticks == v.exp_len - 1);
      if (done_m === 1'b1) begin
        done_cnt++;
        done_at = ticks + 1;
      end
      if (done_m !== exp_done) done_err++;
      if (stick) ticks++;
      cyc++;
    end
    check({nm, "_tick_budget"}, 32'(ticks), 32'(v.exp_len));
    check({nm, "_tx_wave_errs"}, 32'(tx_err), 32'd0);
    check({nm, "_busy_errs"}, 32'(busy_err), 32'd0);
    check({nm, "_done_errs"}, 32'(done_err), 32'd0);
    check({nm, "_done_count"}, 32'(done_cnt), 32'd1);
    check({nm, "_done_on_tick"}, 32'(done_at), 32'(v.exp_len));

    @(negedge clk);
    stick = 1'b0;
    start = hold;
    #1;
    check({nm, "_idle_tx"}, 32'(tx_m), 32'd1);
    check({nm, "_idle_ready"}, 32'(ready_m), 32'd1);
    check({nm, "_idle_done"}, 32'(done_m), 32'd0);
  endtask

  vec_t v;

  initial begin
    // stimulus table: din, parityMode, stopBits2, sTick period, 5-bit dut,
    // expected parity bit, expected frame length in ticks
    vecs[0] = '{8'hA5, 2'b00, 1'b0, 1, 1'b0, 1'b0, 160};  // 8N1
    vecs[1] = '{8'h07, 2'b01, 1'b0, 1, 1'b0, 1'b1, 176};  // even -> 1
    vecs[2] = '{8'h07, 2'b10, 1'b0, 1, 1'b0, 1'b0, 176};  // odd -> 0
    vecs[3] = '{8'h00, 2'b10, 1'b0, 1, 1'b0, 1'b1, 176};  // odd of zero -> 1
    vecs[4] = '{8'hFF, 2'b00, 1'b1, 4, 1'b0, 1'b0, 176};  // 8N2, slow tick
    vecs[5] = '{8'h3C, 2'b11, 1'b1, 2, 1'b0, 1'b0, 176};  // mode 11 = none
    vecs[6] = '{8'h96, 2'b01, 1'b1, 3, 1'b0, 1'b0, 192};  // 8E2 -> 0
    vecs[7] = '{8'h15, 2'b00, 1'b0, 1, 1'b1, 1'b0, 112};  // 5N1
    vecs[8] = '{8'h0B, 2'b01, 1'b1, 1, 1'b1, 1'b1, 144};  // 5E2 -> 1

    reset = 1'b1; stick = 1'b0; din = '0; start = 1'b0; pmode = '0; s2 = 1'b0; use5 = 1'b0;
    repeat (3) @(negedge clk);
    stick = 1'b1;
    start = 1'b1;
    #1;
    check("rst_tx8", 32'(tx8), 32'd1);
    check("rst_ready8", 32'(ready8), 32'd1);
    check("rst_busy8", 32'(busy8), 32'd0);
    check("rst_done8", 32'(done8), 32'd0);
    check("rst_tx5", 32'(tx5), 32'd1);
    check("rst_ready5", 32'(ready5), 32'd1);
    @(negedge clk);
    check("rst_hold_ready8", 32'(ready8), 32'd1);
    reset = 1'b0; stick = 1'b0; start = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      run_frame(vecs[i], 1'b0, 1'b0, $sformatf("vec%0d", i));
      repeat (2) @(negedge clk);
    end

    // inputs changing mid-frame and txStart while busy
    v = '{8'h5A, 2'b01, 1'b0, 1, 1'b0, 1'b0, 176};
    run_frame(v, 1'b0, 1'b1, "isolate");
    @(negedge clk);
    check("isolate_no_second", 32'(ready8), 32'd1);

    // txStart held high: back-to-back frames
    v = '{8'h33, 2'b10, 1'b0, 1, 1'b0, 1'b1, 176};
    run_frame(v, 1'b1, 1'b0, "b2b_0");
    run_frame(v, 1'b1, 1'b0, "b2b_1");
    run_frame(v, 1'b0, 1'b0, "b2b_2");
    @(negedge clk);

    // reset during data bit 3 of 0xA5 (bit 3 = 0)
    use5 = 1'b0; din = 8'hA5; pmode = 2'b00; s2 = 1'b0; start = 1'b1; stick = 1'b0;
    @(posedge clk);
    repeat (70) begin
      @(negedge clk);
      start = 1'b0;
      stick = 1'b1;
    end
    @(negedge clk);
    check("mid_bit3_tx", 32'(tx8), 32'd0);
    check("mid_bit3_busy", 32'(busy8), 32'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_done", 32'(done8), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    stick = 1'b0;
    #1;
    check("mid_rst_tx", 32'(tx8), 32'd1);
    check("mid_rst_ready", 32'(ready8), 32'd1);
    check("mid_rst_busy", 32'(busy8), 32'd0);
    check("mid_rst_done2", 32'(done8), 32'd0);
    run_frame(vecs[0], 1'b0, 1'b0, "after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
